// File: rtl/quad_sample_scheduler.sv
// Periodic quadrature-count sampler: zero offset, per-period velocity, valid/ready output, overrun flag.
// Optional build macro VELOCITY_FILTER_EN adds an IIR velocity filter with shift FILTER_SHIFT.
module quad_sample_scheduler #(
    parameter int FILTER_SHIFT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] count,
    input  logic        enable,
    input  logic [31:0] period,
    input  logic        zero_req,
    input  logic        clear_overrun,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic [31:0] position,
    output logic [31:0] velocity,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, RUN, CAPTURE} state_t;

    state_t      state, state_next;
    logic [31:0] timer;
    logic [31:0] offset;
    logic [31:0] prev_pos;
    logic        first;

    logic        capture;
    logic        eff_first;
    logic [31:0] pos_now;
    logic signed [31:0] delta;
    logic [31:0] vel_now;

    if (FILTER_SHIFT < 0 || FILTER_SHIFT > 31) begin : g_bad_shift
        $error("FILTER_SHIFT must be in 0..31");
    end

    // RUN leaves at timer<=1 so that CAPTURE itself counts as one cycle of the period.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable && period != '0) state_next = RUN;
            RUN: begin
                if (!enable || period == '0) state_next = IDLE;
                else if (timer <= 32'd1)     state_next = CAPTURE;
            end
            CAPTURE: begin
                if (!enable || period == '0) state_next = IDLE;
                else if (period == 32'd1)    state_next = CAPTURE;
                else                         state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    assign capture = (state == CAPTURE);

    // A zero request in the capture cycle is applied before the sample is taken.
    always_comb begin
        eff_first = first || zero_req;
        pos_now   = zero_req ? '0 : count - offset;
        delta     = signed'(pos_now - (zero_req ? 32'd0 : prev_pos));
    end

`ifdef VELOCITY_FILTER_EN
    logic signed [31:0] acc;
    logic signed [31:0] acc_next;

    always_comb begin
        acc_next = eff_first ? '0 : acc + ((delta - acc) >>> FILTER_SHIFT);
        vel_now  = acc_next;
    end

    always_ff @(posedge clk) begin
        if (reset)        acc <= '0;
        else if (capture) acc <= acc_next;
        else if (zero_req) acc <= '0;
    end
`else
    always_comb begin
        vel_now = eff_first ? '0 : delta;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            offset       <= '0;
            prev_pos     <= '0;
            first        <= 1'b1;
            position     <= '0;
            velocity     <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state <= state_next;

            if (zero_req) begin
                offset   <= count;
                prev_pos <= '0;
                first    <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (state_next == RUN) begin
                        timer <= period - 32'd1;
                        first <= 1'b1;
                    end
                end
                RUN: timer <= timer - 32'd1;
                CAPTURE: begin
                    timer    <= period - 32'd1;
                    position <= pos_now;
                    velocity <= vel_now;
                    prev_pos <= pos_now;
                    first    <= 1'b0;
                end
                default: ;
            endcase

            if (capture)                          sample_valid <= 1'b1;
            else if (sample_valid && sample_ready) sample_valid <= 1'b0;

            if (capture && sample_valid && !sample_ready) overrun <= 1'b1;
            else if (clear_overrun)                       overrun <= 1'b0;
        end
    end

endmodule
